// File: rtl/bp_update_sched_if.sv
// Port bundle between the execute lanes / branch history table and the update scheduler.
// Handshake: a lane report transfers on a rising edge where inN_valid and inN_ready are both high;
// upd_valid has no ready because the table consumes one update every cycle it is presented.
interface bp_update_sched_if #(
    parameter int AW    = 4,
    parameter int OCC_W = 3
);
    logic              in0_valid;
    logic [31:0]       in0_pc;
    logic [31:0]       in0_dest;
    logic              in0_taken;
    logic              in0_write;
    logic              in0_ready;
    logic              in1_valid;
    logic [31:0]       in1_pc;
    logic [31:0]       in1_dest;
    logic              in1_taken;
    logic              in1_write;
    logic              in1_ready;
    logic              bht_init;
    logic [AW-1:0]     bht_init_addr;
    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic [31:0]       upd_dest;
    logic              upd_taken;
    logic              upd_write;
    logic              init_done;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output in0_valid, in0_pc, in0_dest, in0_taken, in0_write,
        output in1_valid, in1_pc, in1_dest, in1_taken, in1_write,
        input  in0_ready, in1_ready,
        input  bht_init, bht_init_addr, upd_valid, upd_pc, upd_dest, upd_taken, upd_write,
        input  init_done, occupancy
    );

    modport slave (
        input  in0_valid, in0_pc, in0_dest, in0_taken, in0_write,
        input  in1_valid, in1_pc, in1_dest, in1_taken, in1_write,
        output in0_ready, in1_ready,
        output bht_init, bht_init_addr, upd_valid, upd_pc, upd_dest, upd_taken, upd_write,
        output init_done, occupancy
    );
endinterface

// File: rtl/bp_update_sched.sv
// Branch history table update scheduler: clears the table after reset, then queues
// dual-lane resolved-branch reports in program order and drains them one per cycle.
module bp_update_sched #(
    parameter int DEPTH         = 4,
    parameter int SET_NUM       = 8,
    parameter int ASSOCIATIVITY = 2
) (
    input logic              clk,
    input logic              reset,
    bp_update_sched_if.slave bus
);
    localparam int INIT_N = SET_NUM * ASSOCIATIVITY;
    localparam int AW     = $clog2(INIT_N);
    localparam int PW     = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        taken;
        logic        write;
    } entry_t;

    state_e           state_q, state_d;
    logic [AW-1:0]    init_addr_q, init_addr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] free;
    logic             rdy0, rdy1, acc0, acc1, pop;
    entry_t           mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Lane 1 lands one slot after lane 0 when both are accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (acc0) mem_q[wr_ptr_q] <= '{bus.in0_pc, bus.in0_dest, bus.in0_taken, bus.in0_write};
        if (acc1) mem_q[wr_ptr_q + PW'(acc0)] <= '{bus.in1_pc, bus.in1_dest, bus.in1_taken, bus.in1_write};
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == S_INIT) begin
            init_addr_d = init_addr_q + AW'(1);
            if (init_addr_q == AW'(INIT_N - 1)) state_d = S_RUN;
        end
    end

    // Readiness looks only at the current count, so a pop this cycle never frees a slot early.
    always_comb begin
        free     = OCC_W'(DEPTH) - occ_q;
        rdy0     = (state_q == S_RUN) && (free >= OCC_W'(1));
        rdy1     = (state_q == S_RUN) && (bus.in0_valid ? (free >= OCC_W'(2)) : (free >= OCC_W'(1)));
        acc0     = bus.in0_valid && rdy0;
        acc1     = bus.in1_valid && rdy1;
        pop      = (state_q == S_RUN) && (occ_q != '0);
        wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q + OCC_W'(acc0) + OCC_W'(acc1) - OCC_W'(pop);
    end

    always_comb begin
        bus.bht_init      = (state_q == S_INIT);
        bus.bht_init_addr = (state_q == S_INIT) ? init_addr_q : '0;
        bus.init_done     = (state_q == S_RUN);
        bus.in0_ready     = rdy0;
        bus.in1_ready     = rdy1;
        bus.occupancy     = occ_q;
        bus.upd_valid     = pop;
        bus.upd_pc        = '0;
        bus.upd_dest      = '0;
        bus.upd_taken     = 1'b0;
        bus.upd_write     = 1'b0;
        if (pop) begin
            bus.upd_pc    = mem_q[rd_ptr_q].pc;
            bus.upd_dest  = mem_q[rd_ptr_q].dest;
            bus.upd_taken = mem_q[rd_ptr_q].taken;
            bus.upd_write = mem_q[rd_ptr_q].write;
        end
    end
endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: init sweep, ordering, backpressure, wrap and mid-run reset.
module tb_bp_update_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_update_sched_if #(.AW(4), .OCC_W(3)) bus ();

    bp_update_sched #(.DEPTH(4), .SET_NUM(8), .ASSOCIATIVITY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc, input logic [31:0] dest,
                          input logic t, input logic w);
        bus.in0_valid = v; bus.in0_pc = pc; bus.in0_dest = dest;
        bus.in0_taken = t; bus.in0_write = w;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic [31:0] dest,
                          input logic t, input logic w);
        bus.in1_valid = v; bus.in1_pc = pc; bus.in1_dest = dest;
        bus.in1_taken = t; bus.in1_write = w;
    endtask

    task automatic idle();
        drive0(1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 1'b1, 1'b1);
        drive1(1'b0, 32'hDEAD_0002, 32'hDEAD_0003, 1'b1, 1'b1);
    endtask

    // Walks the 16-step clear; lane valids are dropped before the final step.
    task automatic sweep();
        for (int k = 0; k < 16; k++) begin
            chk("sweep_addr", bus.bht_init_addr, k);
            chk("sweep_init", bus.bht_init, 1'b1);
            chk("sweep_done", bus.init_done, 1'b0);
            chk("sweep_rdy0", bus.in0_ready, 1'b0);
            chk("sweep_rdy1", bus.in1_ready, 1'b0);
            if (k == 15) idle();
            tick();
        end
        chk("sweep_end_done", bus.init_done, 1'b1);
        chk("sweep_end_init", bus.bht_init, 1'b0);
        chk("sweep_end_addr", bus.bht_init_addr, 0);
        chk("sweep_end_occ", bus.occupancy, 0);
        chk("sweep_end_valid", bus.upd_valid, 1'b0);
    endtask

    // Scoreboard: every presented update must be the oldest outstanding accepted report.
    always @(negedge clk) begin
        if (bus.upd_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("sb_unexpected_valid", bus.upd_valid, 1'b0);
            else chk("sb_order", bus.upd_pc, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) tick();
        chk("rst_init", bus.bht_init, 1'b1);
        chk("rst_addr", bus.bht_init_addr, 0);
        chk("rst_done", bus.init_done, 1'b0);
        chk("rst_rdy0", bus.in0_ready, 1'b0);
        chk("rst_rdy1", bus.in1_ready, 1'b0);
        chk("rst_valid", bus.upd_valid, 1'b0);
        chk("rst_pc", bus.upd_pc, 0);
        chk("rst_occ", bus.occupancy, 0);

        // Requesters stay valid through the sweep and must be ignored.
        drive0(1'b1, 32'h0BAD_0000, 32'h0BAD_0004, 1'b1, 1'b1);
        drive1(1'b1, 32'h0BAD_0008, 32'h0BAD_000C, 1'b1, 1'b1);
        reset = 1'b0;
        #1;
        sweep();

        // Single push
        drive0(1'b1, 32'h8000_0010, 32'h8000_0040, 1'b1, 1'b1);
        #1;
        chk("single_rdy0", bus.in0_ready, 1'b1);
        exp_q.push_back(32'h8000_0010);
        tick();
        idle();
        chk("single_valid", bus.upd_valid, 1'b1);
        chk("single_pc", bus.upd_pc, 32'h8000_0010);
        chk("single_dest", bus.upd_dest, 32'h8000_0040);
        chk("single_taken", bus.upd_taken, 1'b1);
        chk("single_write", bus.upd_write, 1'b1);
        chk("single_occ", bus.occupancy, 1);
        tick();
        chk("single_after_valid", bus.upd_valid, 1'b0);
        chk("single_after_pc", bus.upd_pc, 0);
        chk("single_after_dest", bus.upd_dest, 0);
        chk("single_after_taken", bus.upd_taken, 1'b0);
        chk("single_after_write", bus.upd_write, 1'b0);
        chk("single_after_occ", bus.occupancy, 0);

        // Dual push ordering
        drive0(1'b1, 32'h1000_0100, 32'h2000_0000, 1'b0, 1'b1);
        drive1(1'b1, 32'h1000_0200, 32'h2000_0004, 1'b1, 1'b0);
        #1;
        chk("dual_rdy0", bus.in0_ready, 1'b1);
        chk("dual_rdy1", bus.in1_ready, 1'b1);
        chk("dual_occ0", bus.occupancy, 0);
        exp_q.push_back(32'h1000_0100);
        exp_q.push_back(32'h1000_0200);
        tick();
        idle();
        chk("dual_occ2", bus.occupancy, 2);
        chk("dual_pc_a", bus.upd_pc, 32'h1000_0100);
        chk("dual_dest_a", bus.upd_dest, 32'h2000_0000);
        chk("dual_taken_a", bus.upd_taken, 1'b0);
        tick();
        chk("dual_occ1", bus.occupancy, 1);
        chk("dual_pc_b", bus.upd_pc, 32'h1000_0200);
        chk("dual_taken_b", bus.upd_taken, 1'b1);
        chk("dual_write_b", bus.upd_write, 1'b0);
        tick();
        chk("dual_occ_end", bus.occupancy, 0);
        chk("dual_valid_end", bus.upd_valid, 1'b0);

        // Backpressure: with one pop per cycle the count saturates at 3
        drive0(1'b1, 32'h3000_0000, 32'h0, 1'b0, 1'b0);
        drive1(1'b1, 32'h3000_0001, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bp_c0_rdy0", bus.in0_ready, 1'b1);
        chk("bp_c0_rdy1", bus.in1_ready, 1'b1);
        exp_q.push_back(32'h3000_0000);
        exp_q.push_back(32'h3000_0001);
        tick();
        chk("bp_c1_occ", bus.occupancy, 2);
        drive0(1'b1, 32'h3000_0002, 32'h0, 1'b1, 1'b0);
        drive1(1'b1, 32'h3000_0003, 32'h0, 1'b0, 1'b1);
        #1;
        chk("bp_c1_rdy0", bus.in0_ready, 1'b1);
        chk("bp_c1_rdy1", bus.in1_ready, 1'b1);
        exp_q.push_back(32'h3000_0002);
        exp_q.push_back(32'h3000_0003);
        tick();
        chk("bp_c2_occ", bus.occupancy, 3);
        drive0(1'b1, 32'h3000_0004, 32'h0, 1'b0, 1'b0);
        drive1(1'b1, 32'h3000_0005, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bp_free1_rdy0", bus.in0_ready, 1'b1);
        chk("bp_free1_rdy1", bus.in1_ready, 1'b0);
        exp_q.push_back(32'h3000_0004);
        tick();
        chk("bp_c3_occ", bus.occupancy, 3);
        idle();
        drive1(1'b1, 32'h3000_0006, 32'h0, 1'b1, 1'b1);
        #1;
        chk("bp_lane1_only_rdy1", bus.in1_ready, 1'b1);
        exp_q.push_back(32'h3000_0006);
        tick();
        chk("bp_c4_occ", bus.occupancy, 3);
        idle();
        tick();
        chk("bp_c5_occ", bus.occupancy, 2);
        drive0(1'b1, 32'h3000_0007, 32'h0, 1'b0, 1'b0);
        drive1(1'b1, 32'h3000_0008, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bp_free2_rdy0", bus.in0_ready, 1'b1);
        chk("bp_free2_rdy1", bus.in1_ready, 1'b1);
        exp_q.push_back(32'h3000_0007);
        exp_q.push_back(32'h3000_0008);
        tick();
        idle();
        chk("bp_c6_occ", bus.occupancy, 3);
        repeat (3) tick();
        chk("bp_drained_occ", bus.occupancy, 0);
        chk("bp_drained_valid", bus.upd_valid, 1'b0);

        // Wrap-around: single pushes alternating lanes, with gaps
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive0(1'b1, 32'h4000_0000 + 32'(i * 4), 32'h0, 1'b0, 1'b1);
            else            drive1(1'b1, 32'h4000_0000 + 32'(i * 4), 32'h0, 1'b1, 1'b0);
            #1;
            if (i % 2 == 0) chk("wrap_rdy0", bus.in0_ready, 1'b1);
            else            chk("wrap_rdy1", bus.in1_ready, 1'b1);
            exp_q.push_back(32'h4000_0000 + 32'(i * 4));
            tick();
            idle();
            if (i % 3 == 2) tick();
        end
        repeat (3) tick();
        chk("wrap_occ", bus.occupancy, 0);
        chk("wrap_drained", exp_q.size(), 0);

        // Mid-run reset with three entries queued
        drive0(1'b1, 32'h5000_0000, 32'h0, 1'b0, 1'b0);
        drive1(1'b1, 32'h5000_0004, 32'h0, 1'b0, 1'b0);
        exp_q.push_back(32'h5000_0000);
        exp_q.push_back(32'h5000_0004);
        tick();
        drive0(1'b1, 32'h5000_0008, 32'h0, 1'b0, 1'b0);
        drive1(1'b1, 32'h5000_000C, 32'h0, 1'b0, 1'b0);
        #1;
        chk("mrst_rdy1", bus.in1_ready, 1'b1);
        exp_q.push_back(32'h5000_0008);
        exp_q.push_back(32'h5000_000C);
        tick();
        idle();
        chk("mrst_occ3", bus.occupancy, 3);
        reset = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b0;
        #1;
        chk("mrst_valid", bus.upd_valid, 1'b0);
        chk("mrst_occ0", bus.occupancy, 0);
        chk("mrst_done", bus.init_done, 1'b0);
        sweep();
        for (int i = 0; i < 4; i++) begin
            chk("mrst_no_stale", bus.upd_valid, 1'b0);
            tick();
        end
        chk("mrst_final_occ", bus.occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
